fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences the instruction-memory port for the RV32I core. It issues in-order fetch requests, buffers returned instructions toward decode, and applies PC redirects from `branch_jump_unit`. On a redirect it discards stale in-flight responses. It sits between the instruction memory interface and the IF/ID boundary, and supplies decode with the next-instruction address (`pc+4`) that `branch_jump_unit` consumes as `i_pc`.

---
 rtl/riscv_defs.sv | 13 +
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared definitions for the instruction-fetch slice
// Contents: fetch_state_t (BOOT/FETCH/DRAIN) and the default reset vector.
package riscv_defs;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory request/response port
// Signals: req/addr (fetch request), gnt (request accepted),
//          rvalid/rdata (in-order response).
// Modports: master = fetch side, slave = memory side.
interface fetch_sequencer_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_WORD = 32
) ();

    logic               req;
    logic [NB_ADDR-1:0] addr;
    logic               gnt;
    logic               rvalid;
    logic [NB_WORD-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with clear and occupancy count
// Ports: i_clock, i_reset (async, active-low), i_push/i_data, i_pop,
//        i_clear (drops all entries), o_data (head entry), o_count.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop on an empty FIFO is ignored so the pointers never run ahead.
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32I instruction-fetch controller
// Ports: i_clock, i_reset (async, active-low);
//        i_branch_taken/i_branch_addr (PC redirect);
//        imem (master side of fetch_sequencer_if);
//        o_if_valid/o_if_instruction/o_if_pc/o_if_pc_next, i_if_ready (to decode);
//        o_misaligned (one-cycle pulse for a redirect target with addr[1:0] != 0).
module fetch_sequencer
    import riscv_defs::*;
#(
    parameter int                 NB_ADDR         = 32,
    parameter int                 NB_WORD         = 32,
    parameter logic [NB_ADDR-1:0] RESET_VECTOR    = DEF_RESET_VECTOR,
    parameter int                 MAX_OUTSTANDING = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_branch_taken,
    input  logic [NB_ADDR-1:0] i_branch_addr,
    fetch_sequencer_if.master  imem,
    output logic               o_if_valid,
    output logic [NB_WORD-1:0] o_if_instruction,
    output logic [NB_ADDR-1:0] o_if_pc,
    output logic [NB_ADDR-1:0] o_if_pc_next,
    input  logic               i_if_ready,
    output logic               o_misaligned
);

    localparam int CW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int NB_BUF = NB_ADDR + NB_WORD;

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [NB_ADDR-1:0] r_pc;
    logic [CW-1:0]      r_drop_cnt;
    logic [CW-1:0]      w_drop_nxt;
    logic               r_misaligned;

    logic               w_redirect;
    logic               w_req;
    logic               w_issue;
    logic               w_resp_keep;
    logic               w_buf_pop;
    logic [CW-1:0]      w_outstanding;
    logic [CW-1:0]      w_buf_cnt;
    logic [CW:0]        w_occupancy;
    logic [NB_ADDR-1:0] w_tag;
    logic [NB_BUF-1:0]  w_buf_data;

    // A redirect during BOOT is ignored.
    assign w_redirect  = i_branch_taken && (r_state != BOOT);
    assign w_issue     = w_req && imem.gnt;
    // Every in-flight request and every buffered instruction holds a buffer slot,
    // so a returning response always finds room.
    assign w_occupancy = {1'b0, w_outstanding} + {1'b0, w_buf_cnt};
    assign w_resp_keep = imem.rvalid && (r_drop_cnt == '0) && !w_redirect;
    assign o_if_valid  = (w_buf_cnt != '0) && !w_redirect;
    assign w_buf_pop   = o_if_valid && i_if_ready;

    // Tag queue: its occupancy is exactly the number of outstanding requests.
    fetch_fifo #(
        .WIDTH (NB_ADDR),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_queue (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_issue),
        .i_data  (r_pc),
        .i_pop   (imem.rvalid),
        .i_clear (1'b0),
        .o_data  (w_tag),
        .o_count (w_outstanding)
    );

    fetch_fifo #(
        .WIDTH (NB_BUF),
        .DEPTH (MAX_OUTSTANDING)
    ) u_out_buf (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_resp_keep),
        .i_data  ({w_tag, imem.rdata}),
        .i_pop   (w_buf_pop),
        .i_clear (w_redirect),
        .o_data  (w_buf_data),
        .o_count (w_buf_cnt)
    );

    // Responses still in flight at a redirect are stale; one arriving in the
    // redirect cycle itself is already accounted for by subtracting rvalid.
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (w_redirect) begin
            w_drop_nxt = w_outstanding - CW'(imem.rvalid);
        end else if (imem.rvalid && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = FETCH;
            FETCH:   if (w_redirect && (w_drop_nxt != '0)) w_state_nxt = DRAIN;
            DRAIN:   if (w_drop_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        if (r_state != BOOT) begin
            w_req = !i_branch_taken && (w_occupancy < (CW + 1)'(MAX_OUTSTANDING));
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pc         <= RESET_VECTOR;
            r_drop_cnt   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_drop_cnt   <= w_drop_nxt;
            r_misaligned <= w_redirect && (i_branch_addr[1:0] != 2'b00);
            if (w_redirect) begin
                r_pc <= {i_branch_addr[NB_ADDR-1:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + NB_ADDR'(4);
            end
        end
    end

    assign imem.req     = w_req;
    assign imem.addr    = r_pc;
    assign o_misaligned = r_misaligned;

    assign {o_if_pc, o_if_instruction} = w_buf_data;
    assign o_if_pc_next = o_if_pc + NB_ADDR'(4);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    import riscv_defs::*;

    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RV      = DEF_RESET_VECTOR;

    typedef struct {
        logic [31:0] addr;
        int          gcyc;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_addr = '0;
    logic        ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;
    logic        mis;

    fetch_sequencer_if #(.NB_ADDR(32), .NB_WORD(32)) imem ();

    fetch_sequencer #(
        .NB_ADDR         (32),
        .NB_WORD         (32),
        .RESET_VECTOR    (RV),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_branch_taken   (br),
        .i_branch_addr    (br_addr),
        .imem             (imem),
        .o_if_valid       (if_valid),
        .o_if_instruction (if_instr),
        .o_if_pc          (if_pc),
        .o_if_pc_next     (if_pc_next),
        .i_if_ready       (ready),
        .o_misaligned     (mis)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          first_valid_cyc = -1;
    mreq_t       mq[$];
    logic [31:0] sb_q[$];
    logic [31:0] exp_fetch = RV;
    logic        exp_mis = 1'b0;
    logic        gnt_en = 1'b1;
    logic        rsp_en = 1'b1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic        chk_next_req = 1'b0;
    logic        await_first = 1'b0;
    logic [31:0] await_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        check_val("rst_req", imem.req, 1'b0);
        check_val("rst_addr", imem.addr, RV);
        check_val("rst_valid", if_valid, 1'b0);
        check_val("rst_instr", if_instr, 32'h0);
        check_val("rst_pc", if_pc, 32'h0);
        check_val("rst_pc_next", if_pc_next, 32'h4);
        check_val("rst_misaligned", mis, 1'b0);
    endtask

    // Called at the falling edge: inputs and outputs are stable for the
    // transaction that completes at the next rising edge.
    task automatic score();
        logic [31:0] p;
        mreq_t       m;
        if (cyc == 0) check_val("boot_no_req", imem.req, 1'b0);
        if (cyc == 1) begin
            check_val("first_req", imem.req, 1'b1);
            check_val("first_addr", imem.addr, RV);
        end
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        check_val("misaligned", mis, exp_mis);
        if (prev_stall && !br) begin
            check_val("hold_valid", if_valid, 1'b1);
            check_val("hold_pc", if_pc, prev_pc);
            check_val("hold_instr", if_instr, prev_instr);
        end
        if (chk_next_req) begin
            check_val("req_after_redirect", imem.req, 1'b1);
            check_val("addr_after_redirect", imem.addr, exp_fetch);
            chk_next_req = 1'b0;
        end
        if (br) begin
            check_val("valid_in_redirect", if_valid, 1'b0);
            check_val("req_in_redirect", imem.req, 1'b0);
            sb_q.delete();
        end else if (if_valid && ready) begin
            check_val("xfer_expected", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                check_val("if_pc", if_pc, p);
                check_val("if_instr", if_instr, mem_word(p));
                check_val("if_pc_next", if_pc_next, p + 32'd4);
                if (await_first) begin
                    check_val("first_pc_after_redirect", if_pc, await_pc);
                    await_first = 1'b0;
                end
            end
        end
        if (imem.req && imem.gnt) begin
            check_val("fetch_addr", imem.addr, exp_fetch);
            sb_q.push_back(exp_fetch);
            m.addr = imem.addr;
            m.gcyc = cyc;
            mq.push_back(m);
            exp_fetch = exp_fetch + 32'd4;
            check_val("outstanding_le_max", mq.size() <= MAX_OUT, 1'b1);
        end
        if (br) begin
            exp_fetch   = {br_addr[31:2], 2'b00};
            await_first = 1'b1;
            await_pc    = exp_fetch;
        end
        exp_mis    = br && (br_addr[1:0] != 2'b00);
        prev_stall = if_valid && !ready && !br;
        prev_pc    = if_pc;
        prev_instr = if_instr;
    endtask

    // Memory side: in-order responses, at least one cycle after grant.
    task automatic drive();
        mreq_t m;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        if (rsp_en && mq.size() > 0 && mq[0].gcyc < cyc) begin
            m = mq.pop_front();
            imem.rvalid = 1'b1;
            imem.rdata  = mem_word(m.addr);
        end
        imem.gnt = gnt_en;
    endtask

    task automatic step();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        br = 1'b0;
    endtask

    task automatic release_reset();
        mq.delete();
        sb_q.delete();
        exp_fetch       = RV;
        exp_mis         = 1'b0;
        prev_stall      = 1'b0;
        chk_next_req    = 1'b0;
        await_first     = 1'b0;
        first_valid_cyc = -1;
        imem.rvalid     = 1'b0;
        imem.rdata      = '0;
        imem.gnt        = gnt_en;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        ready       = 1'b1;
        #12;
        check_reset_vals();
        release_reset();

        repeat (8) step();
        check_val("first_valid_cycle", first_valid_cyc, 3);

        ready = 1'b0;
        repeat (5) step();
        ready = 1'b1;
        repeat (4) step();

        rsp_en = 1'b0;
        repeat (3) step();
        check_val("two_outstanding", mq.size(), MAX_OUT);
        br = 1'b1;
        br_addr = 32'h0000_0100;
        step();
        rsp_en = 1'b1;
        repeat (6) step();

        rsp_en = 1'b0;
        repeat (3) step();
        br = 1'b1;
        br_addr = 32'h0000_0180;
        rsp_en = 1'b1;
        step();
        br = 1'b1;
        br_addr = 32'h0000_0200;
        step();
        repeat (6) step();

        br = 1'b1;
        br_addr = 32'h0000_0102;
        chk_next_req = 1'b0;
        step();
        chk_next_req = 1'b1;
        repeat (6) step();

        repeat (300) begin
            gnt_en = ($urandom_range(0, 3) != 0);
            rsp_en = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                br = 1'b1;
                br_addr = $urandom;
            end
            step();
        end

        gnt_en = 1'b0;
        rsp_en = 1'b1;
        ready  = 1'b1;
        repeat (10) step();
        check_val("sb_drained", sb_q.size(), 0);

        gnt_en = 1'b1;
        ready  = 1'b0;
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        ready = 1'b1;
        release_reset();
        repeat (8) step();
        check_val("first_valid_cycle_after_reset", first_valid_cyc, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
